// File: rtl/cavlc_pkg.sv
// Shared CAVLC constants: field widths, nC range encodings and token legality.
package cavlc_pkg;
    localparam int TC_W       = 5;
    localparam int T1_W       = 2;
    localparam int NC_W       = 2;
    localparam int CT_MAX_LEN = 16;
    localparam int CT_LEN_W   = 5;
    localparam int CNT_W      = $clog2(CT_MAX_LEN);

    localparam logic [NC_W-1:0] NC_0_2  = 2'd0;
    localparam logic [NC_W-1:0] NC_2_4  = 2'd1;
    localparam logic [NC_W-1:0] NC_4_8  = 2'd2;
    localparam logic [NC_W-1:0] NC_8_UP = 2'd3;

    function automatic logic ct_illegal(input logic [TC_W-1:0] tc, input logic [T1_W-1:0] t1);
        return ({3'd0, t1} > tc) || ((t1 == 2'd3) && (tc < 5'd3)) || (tc > 5'd16);
    endfunction
endpackage

// File: rtl/coeff_token_enc_lut.sv
// Combinational coeff_token codeword lookup (Table 9-5 luma columns plus the 6-bit FLC).
module coeff_token_enc_lut
    import cavlc_pkg::*;
(
    input  logic [TC_W-1:0]       tc,
    input  logic [T1_W-1:0]       t1,
    input  logic [NC_W-1:0]       nc,
    output logic [CT_MAX_LEN-1:0] code,
    output logic [CT_LEN_W-1:0]   len,
    output logic                  illegal
);
    // One row per TotalCoeff; fields ordered TrailingOnes 0,1,2,3 from the top. VLC codes all fit in 4 bits.
    localparam logic [19:0] LEN_NC0 [17] = '{
        {5'd1,  5'd0,  5'd0,  5'd0 }, {5'd6,  5'd2,  5'd0,  5'd0 }, {5'd8,  5'd6,  5'd3,  5'd0 },
        {5'd9,  5'd8,  5'd7,  5'd5 }, {5'd10, 5'd9,  5'd8,  5'd6 }, {5'd11, 5'd10, 5'd9,  5'd7 },
        {5'd13, 5'd11, 5'd10, 5'd8 }, {5'd13, 5'd13, 5'd11, 5'd9 }, {5'd13, 5'd13, 5'd13, 5'd10},
        {5'd14, 5'd14, 5'd13, 5'd11}, {5'd14, 5'd14, 5'd14, 5'd13}, {5'd15, 5'd15, 5'd14, 5'd14},
        {5'd15, 5'd15, 5'd15, 5'd14}, {5'd16, 5'd15, 5'd15, 5'd15}, {5'd16, 5'd16, 5'd16, 5'd15},
        {5'd16, 5'd16, 5'd16, 5'd16}, {5'd16, 5'd16, 5'd16, 5'd16}
    };
    localparam logic [15:0] CODE_NC0 [17] = '{
        16'h1000, 16'h5100, 16'h7410, 16'h7653, 16'h7653, 16'h7654, 16'hF654, 16'hBE54, 16'h8AD4,
        16'hFE94, 16'hBADC, 16'hFE9C, 16'hBAD8, 16'hF19C, 16'hBED8, 16'h7A9C, 16'h4658
    };
    localparam logic [19:0] LEN_NC2 [17] = '{
        {5'd2,  5'd0,  5'd0,  5'd0 }, {5'd6,  5'd2,  5'd0,  5'd0 }, {5'd6,  5'd5,  5'd3,  5'd0 },
        {5'd7,  5'd6,  5'd6,  5'd4 }, {5'd8,  5'd6,  5'd6,  5'd4 }, {5'd8,  5'd7,  5'd7,  5'd5 },
        {5'd9,  5'd8,  5'd8,  5'd6 }, {5'd11, 5'd9,  5'd9,  5'd6 }, {5'd11, 5'd11, 5'd11, 5'd7 },
        {5'd12, 5'd11, 5'd11, 5'd9 }, {5'd12, 5'd12, 5'd12, 5'd11}, {5'd12, 5'd12, 5'd12, 5'd11},
        {5'd13, 5'd13, 5'd13, 5'd12}, {5'd13, 5'd13, 5'd13, 5'd13}, {5'd13, 5'd14, 5'd13, 5'd13},
        {5'd14, 5'd14, 5'd14, 5'd13}, {5'd14, 5'd14, 5'd14, 5'd14}
    };
    localparam logic [15:0] CODE_NC2 [17] = '{
        16'h3000, 16'hB200, 16'h7730, 16'h7A95, 16'h7654, 16'h4656, 16'h7658, 16'hF654, 16'hBED4,
        16'hFA94, 16'hBEDC, 16'h8A98, 16'hFEDC, 16'hBA9C, 16'h7B68, 16'h98A1, 16'h7654
    };
    localparam logic [19:0] LEN_NC4 [17] = '{
        {5'd4,  5'd0,  5'd0,  5'd0 }, {5'd6,  5'd4,  5'd0,  5'd0 }, {5'd6,  5'd5,  5'd4,  5'd0 },
        {5'd6,  5'd5,  5'd5,  5'd4 }, {5'd7,  5'd5,  5'd5,  5'd4 }, {5'd7,  5'd5,  5'd5,  5'd4 },
        {5'd7,  5'd6,  5'd6,  5'd4 }, {5'd7,  5'd6,  5'd6,  5'd4 }, {5'd8,  5'd7,  5'd7,  5'd5 },
        {5'd8,  5'd8,  5'd7,  5'd6 }, {5'd9,  5'd8,  5'd8,  5'd7 }, {5'd9,  5'd9,  5'd8,  5'd8 },
        {5'd9,  5'd9,  5'd9,  5'd8 }, {5'd10, 5'd9,  5'd9,  5'd9 }, {5'd10, 5'd10, 5'd10, 5'd10},
        {5'd10, 5'd10, 5'd10, 5'd10}, {5'd10, 5'd10, 5'd10, 5'd10}
    };
    localparam logic [15:0] CODE_NC4 [17] = '{
        16'hF000, 16'hFE00, 16'hBFD0, 16'h8CEC, 16'hFABB, 16'hB89A, 16'h9ED9, 16'h8A98, 16'hFEDD,
        16'hBEAC, 16'hFADC, 16'hBE9C, 16'h8AD8, 16'hD79C, 16'h9CBA, 16'h5876, 16'h1432
    };

    logic [TC_W-1:0] tc_idx;
    logic [TC_W-1:0] tc_m1;
    logic [19:0]     len_row;
    logic [15:0]     code_row;
    logic [4:0]      vlc_len;
    logic [3:0]      vlc_code;

    always_comb begin
        illegal = ct_illegal(tc, t1);
        tc_idx  = illegal ? '0 : tc;
        tc_m1   = tc - TC_W'(1);

        case (nc)
            NC_0_2:  begin len_row = LEN_NC0[tc_idx]; code_row = CODE_NC0[tc_idx]; end
            NC_2_4:  begin len_row = LEN_NC2[tc_idx]; code_row = CODE_NC2[tc_idx]; end
            default: begin len_row = LEN_NC4[tc_idx]; code_row = CODE_NC4[tc_idx]; end
        endcase

        case (t1)
            2'd0:    begin vlc_len = len_row[19:15]; vlc_code = code_row[15:12]; end
            2'd1:    begin vlc_len = len_row[14:10]; vlc_code = code_row[11:8];  end
            2'd2:    begin vlc_len = len_row[9:5];   vlc_code = code_row[7:4];   end
            default: begin vlc_len = len_row[4:0];   vlc_code = code_row[3:0];   end
        endcase

        if (nc == NC_8_UP) begin
            len  = CT_LEN_W'(6);
            code = (tc == '0) ? 16'h0003 : {10'd0, tc_m1[3:0], t1};
        end else begin
            len  = vlc_len;
            code = {12'd0, vlc_code};
        end
    end
endmodule

// File: rtl/coeff_token_enc.sv
// coeff_token encoder: accepts one token, looks up its codeword and shifts it out MSB-first.
module coeff_token_enc
    import cavlc_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            InValid,
    output logic            InReady,
    input  logic [TC_W-1:0] TotalCoeff,
    input  logic [T1_W-1:0] TrailingOnes,
    input  logic [NC_W-1:0] NcRange,
    output logic            OutValid,
    input  logic            OutReady,
    output logic            OutBit,
    output logic            OutLast,
    output logic            Error
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CT_MAX_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  error_q, error_d;

    logic [CT_MAX_LEN-1:0] lut_code;
    logic [CT_LEN_W-1:0]   lut_len;
    logic                  lut_illegal;
    logic                  last_bit;
    logic                  accept;
    logic                  out_fire;

    coeff_token_enc_lut u_lut (
        .tc      (TotalCoeff),
        .t1      (TrailingOnes),
        .nc      (NcRange),
        .code    (lut_code),
        .len     (lut_len),
        .illegal (lut_illegal)
    );

    assign OutValid = (state_q == ST_SHIFT);
    assign last_bit = OutValid && (bit_cnt_q == '0);
    assign OutBit   = OutValid & shreg_q[CT_MAX_LEN-1];
    assign OutLast  = last_bit;
    // Accepting during the final bit lets the next codeword follow with no idle cycle.
    assign InReady  = (state_q == ST_IDLE) || (last_bit && OutReady);
    assign Error    = error_q;
    assign accept   = InValid && InReady;
    assign out_fire = OutValid && OutReady;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        error_d   = 1'b0;

        if (out_fire) begin
            shreg_d   = {shreg_q[CT_MAX_LEN-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            if (last_bit) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        end

        if (accept) begin
            if (lut_illegal) begin
                error_d = 1'b1;
            end else begin
                state_d   = ST_SHIFT;
                shreg_d   = lut_code << (CT_LEN_W'(CT_MAX_LEN) - lut_len);
                bit_cnt_d = lut_len[CNT_W-1:0] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            error_q   <= error_d;
        end
    end
endmodule

// File: tb/tb_coeff_token_enc.sv
// Self-checking bench for coeff_token_enc; emitted bits are decoded back to tokens against a reference table.
module tb_coeff_token_enc;
    logic       Clk = 1'b0;
    logic       Rst;
    logic       InValid;
    logic       InReady;
    logic [4:0] TotalCoeff;
    logic [1:0] TrailingOnes;
    logic [1:0] NcRange;
    logic       OutValid;
    logic       OutReady;
    logic       OutBit;
    logic       OutLast;
    logic       Error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int tc;
        int t1;
        int nc;
    } tok_t;
    tok_t exp_q[$];

    // Reference decode table, index TotalCoeff*4 + TrailingOnes, columns nC 0-2, 2-4, 4-8.
    int ref_len [3][68] = '{
        '{ 1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,  10, 9, 8, 6,
          11,10, 9, 7,  13,11,10, 8,  13,13,11, 9,  13,13,13,10,  14,14,13,11,
          14,14,14,13,  15,15,14,14,  15,15,15,14,  16,15,15,15,  16,16,16,15,
          16,16,16,16,  16,16,16,16},
        '{ 2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,   8, 6, 6, 4,
           8, 7, 7, 5,   9, 8, 8, 6,  11, 9, 9, 6,  11,11,11, 7,  12,11,11, 9,
          12,12,12,11,  12,12,12,11,  13,13,13,12,  13,13,13,13,  13,14,13,13,
          14,14,14,13,  14,14,14,14},
        '{ 4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,   7, 5, 5, 4,
           7, 5, 5, 4,   7, 6, 6, 4,   7, 6, 6, 4,   8, 7, 7, 5,   8, 8, 7, 6,
           9, 8, 8, 7,   9, 9, 8, 8,   9, 9, 9, 8,  10, 9, 9, 9,  10,10,10,10,
          10,10,10,10,  10,10,10,10}
    };
    int ref_code [3][68] = '{
        '{ 1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,   7, 6, 5, 3,
           7, 6, 5, 4,  15, 6, 5, 4,  11,14, 5, 4,   8,10,13, 4,  15,14, 9, 4,
          11,10,13,12,  15,14, 9,12,  11,10,13, 8,  15, 1, 9,12,  11,14,13, 8,
           7,10, 9,12,   4, 6, 5, 8},
        '{ 3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,   7, 6, 5, 4,
           4, 6, 5, 6,   7, 6, 5, 8,  15, 6, 5, 4,  11,14,13, 4,  15,10, 9, 4,
          11,14,13,12,   8,10, 9, 8,  15,14,13,12,  11,10, 9,12,   7,11, 6, 8,
           9, 8,10, 1,   7, 6, 5, 4},
        '{15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,  15,10,11,11,
          11, 8, 9,10,   9,14,13, 9,   8,10, 9, 8,  15,14,13,13,  11,14,10,12,
          15,10,13,12,  11,14, 9,12,   8,10,13, 8,  13, 7, 9,12,   9,12,11,10,
           5, 8, 7, 6,   1, 4, 3, 2}
    };

    coeff_token_enc dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .InValid      (InValid),
        .InReady      (InReady),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .NcRange      (NcRange),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutBit       (OutBit),
        .OutLast      (OutLast),
        .Error        (Error)
    );

    initial forever #5 Clk = ~Clk;

    function automatic bit tb_legal(input int tc, input int t1);
        return (tc <= 16) && (t1 <= tc) && !(t1 == 3 && tc < 3);
    endfunction

    function automatic bit decode(input int nc, input int acc, input int n, output int tc, output int t1);
        tc = -1;
        t1 = -1;
        if (nc == 3) begin
            if (n != 6) return 1'b0;
            if (acc == 3) begin
                tc = 0;
                t1 = 0;
            end else begin
                tc = (acc >> 2) + 1;
                t1 = acc & 3;
            end
            return 1'b1;
        end
        for (int i = 0; i < 68; i++) begin
            if (ref_len[nc][i] == n && ref_code[nc][i] == acc) begin
                tc = i / 4;
                t1 = i % 4;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Scoreboard consumer: accumulates bits of the current codeword and decodes them.
    initial begin : monitor
        int   acc;
        int   nbits;
        int   dtc;
        int   dt1;
        bit   found;
        tok_t e;
        acc   = 0;
        nbits = 0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                acc   = 0;
                nbits = 0;
            end else begin
                if (Error) begin
                    checks++;
                    if (OutValid !== 1'b0) begin
                        failures++;
                        $display("FAIL error_valid_overlap out_valid=%0b want 0", OutValid);
                    end
                end
                if (OutValid && OutReady) begin
                    acc = (acc << 1) | int'(OutBit);
                    nbits++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_bit bit=%0b want no output", OutBit);
                        acc   = 0;
                        nbits = 0;
                    end else begin
                        found = decode(exp_q[0].nc, acc, nbits, dtc, dt1);
                        if (found || OutLast || nbits >= 16) begin
                            e = exp_q.pop_front();
                            checks++;
                            if (!found || OutLast !== 1'b1 || dtc != e.tc || dt1 != e.t1) begin
                                failures++;
                                $display("FAIL roundtrip nc=%0d got tc=%0d t1=%0d last=%0b nbits=%0d want tc=%0d t1=%0d last=1",
                                         e.nc, dtc, dt1, OutLast, nbits, e.tc, e.t1);
                            end
                            acc   = 0;
                            nbits = 0;
                        end
                    end
                end
            end
        end
    end

    // Callers enter just after a rising edge; returns just after the accepting edge.
    task automatic send_token(input int tc, input int t1, input int nc);
        tok_t t;
        int   n = 0;
        TotalCoeff   = 5'(tc);
        TrailingOnes = 2'(t1);
        NcRange      = 2'(nc);
        InValid      = 1'b1;
        @(negedge Clk);
        while (!InReady && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout tc=%0d t1=%0d nc=%0d in_ready=%0b want 1", tc, t1, nc, InReady);
        end else if (tb_legal(tc, t1)) begin
            t.tc = tc;
            t.t1 = t1;
            t.nc = nc;
            exp_q.push_back(t);
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || OutValid) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || OutValid !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d out_valid=%0b want 0 and 0", exp_q.size(), OutValid);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (InReady !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want 1", InReady); end
        checks++;
        if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want 0", OutValid); end
        checks++;
        if (OutBit !== 1'b0) begin failures++; $display("FAIL reset_out_bit got=%0b want 0", OutBit); end
        checks++;
        if (OutLast !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b want 0", OutLast); end
        checks++;
        if (Error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b want 0", Error); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_single_bit();
        tok_t t;
        TotalCoeff = 5'd0; TrailingOnes = 2'd0; NcRange = 2'd0; InValid = 1'b1;
        @(negedge Clk);
        checks++;
        if (InReady !== 1'b1) begin failures++; $display("FAIL single_in_ready_idle got=%0b want 1", InReady); end
        t.tc = 0; t.t1 = 0; t.nc = 0;
        exp_q.push_back(t);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        @(negedge Clk);
        checks++;
        if ({OutValid, OutBit, OutLast, InReady} !== 4'b1111) begin
            failures++;
            $display("FAIL single_first_cycle valid/bit/last/ready got=%b want 1111", {OutValid, OutBit, OutLast, InReady});
        end
        @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if (OutValid !== 1'b0) begin failures++; $display("FAIL single_back_idle out_valid=%0b want 0", OutValid); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_back_to_back();
        tok_t t;
        int   n   = 0;
        bit   hit = 1'b0;
        send_token(1, 0, 0);
        TotalCoeff = 5'd2; TrailingOnes = 2'd2; NcRange = 2'd0; InValid = 1'b1;
        while (!hit && n < 20) begin
            @(negedge Clk);
            n++;
            if (InReady) hit = 1'b1;
        end
        checks++;
        if (!hit || OutLast !== 1'b1 || n != 6) begin
            failures++;
            $display("FAIL b2b_accept_point got cycle=%0d last=%0b want cycle=6 last=1", n, OutLast);
        end
        if (hit) begin
            t.tc = 2; t.t1 = 2; t.nc = 0;
            exp_q.push_back(t);
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        @(negedge Clk);
        checks++;
        if (OutValid !== 1'b1 || OutBit !== 1'b0 || OutLast !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_bubble valid/bit/last got=%0b%0b%0b want 100", OutValid, OutBit, OutLast);
        end
        wait_idle();
    endtask

    task automatic test_flc();
        logic [5:0] bits;
        send_token(3, 2, 3);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            bits = {bits[4:0], (OutValid ? OutBit : 1'bx)};
        end
        checks++;
        if (bits !== 6'b001010) begin failures++; $display("FAIL flc_tc3_t1_2 got=%b want 001010", bits); end
        @(posedge Clk);
        #1;
        send_token(0, 0, 3);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            bits = {bits[4:0], (OutValid ? OutBit : 1'bx)};
        end
        checks++;
        if (bits !== 6'b000011) begin failures++; $display("FAIL flc_tc0 got=%b want 000011", bits); end
        wait_idle();
    endtask

    task automatic test_stall();
        OutReady = 1'b1;
        send_token(0, 0, 1);
        @(negedge Clk);
        checks++;
        if (OutBit !== 1'b1 || OutLast !== 1'b0) begin
            failures++;
            $display("FAIL stall_bit0 bit/last got=%0b%0b want 10", OutBit, OutLast);
        end
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            checks++;
            if ({OutValid, OutBit, OutLast, InReady} !== 4'b1110) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d valid/bit/last/ready got=%b want 1110", i, {OutValid, OutBit, OutLast, InReady});
            end
            @(posedge Clk);
            #1;
        end
        OutReady = 1'b1;
        @(negedge Clk);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if (OutValid !== 1'b0) begin failures++; $display("FAIL stall_done out_valid=%0b want 0", OutValid); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_illegal();
        int bad_tc [4] = '{1, 2, 17, 0};
        int bad_t1 [4] = '{2, 3, 0, 1};
        int bad_nc [4] = '{0, 1, 3, 2};
        for (int i = 0; i < 4; i++) begin
            send_token(bad_tc[i], bad_t1[i], bad_nc[i]);
            @(negedge Clk);
            checks++;
            if ({Error, OutValid, InReady} !== 3'b101) begin
                failures++;
                $display("FAIL illegal_pulse idx=%0d err/valid/ready got=%b want 101", i, {Error, OutValid, InReady});
            end
            @(posedge Clk);
            #1;
            @(negedge Clk);
            checks++;
            if ({Error, OutValid} !== 2'b00) begin
                failures++;
                $display("FAIL illegal_after idx=%0d err/valid got=%b want 00", i, {Error, OutValid});
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits;
        send_token(1, 0, 0);
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_mid_immediate out_valid=%0b want 0", OutValid); end
        @(negedge Clk);
        checks++;
        if (OutValid !== 1'b0 || OutLast !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_held valid/last got=%0b%0b want 00", OutValid, OutLast);
        end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_flush out_valid=%0b want 0", OutValid); end
        @(posedge Clk);
        #1;
        send_token(0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            bits = {bits[2:0], (OutValid ? OutBit : 1'bx)};
        end
        checks++;
        if (bits !== 4'b1111) begin failures++; $display("FAIL rst_mid_next_token got=%b want 1111", bits); end
        wait_idle();
    endtask

    task automatic test_sweep();
        OutReady = 1'b1;
        for (int nc = 0; nc < 4; nc++)
            for (int tc = 0; tc <= 16; tc++)
                for (int t1 = 0; t1 < 4; t1++)
                    if (tb_legal(tc, t1)) send_token(tc, t1, nc);
        wait_idle();
    endtask

    initial begin
        Rst          = 1'b1;
        InValid      = 1'b0;
        OutReady     = 1'b1;
        TotalCoeff   = 5'd0;
        TrailingOnes = 2'd0;
        NcRange      = 2'd0;
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_flc();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_sweep();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue pending=%0d want 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
